// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C receive sequencer.
// No logic: FSM state encoding, error codes and default sizing.
// Imported by i2c_rx_ctrl.
package i2c_pkg;

    localparam int MAX_BYTES = 4;
    localparam int CNT_W     = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BIT  = 2'd1,
        ST_ACK  = 2'd2,
        ST_DONE = 2'd3
    } rx_state_t;

    localparam logic [1:0] ERR_SIZE  = 2'd1;
    localparam logic [1:0] ERR_FULL  = 2'd2;
    localparam logic [1:0] ERR_ABORT = 2'd3;

endpackage

// File: rtl/i2c_rx_ctrl.sv
// Sequencer for the I2C receive shifter and its two ping-pong word buffers.
// Latency: start_rx accepted in 1 cycle, scl_rise to bit_valid 1 cycle.
// Backpressure: a start is refused with an error while its target buffer is still full.
module i2c_rx_ctrl #(
    parameter int MAX_BYTES = i2c_pkg::MAX_BYTES,
    parameter int CNT_W     = i2c_pkg::CNT_W,
    parameter bit NACK_LAST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_rx,
    input  logic [3:0]       size,
    input  logic             scl_rise,
    input  logic             scl_fall,
    input  logic             sda_in,
    input  logic             abort,
    input  logic [1:0]       buf_release,
    output logic             rx_en,
    output logic             latch0,
    output logic             latch1,
    output logic             rx_bit,
    output logic [CNT_W-1:0] rx_count,
    output logic             bit_valid,
    output logic             ack_drive,
    output logic [1:0]       buf_full,
    output logic             busy,
    output logic             rx_done,
    output logic             rx_err,
    output logic [1:0]       err_code
);
    import i2c_pkg::*;

    localparam logic [3:0] MAX_SZ = 4'(MAX_BYTES);

    rx_state_t        state_q, state_d;
    logic             wr_sel_q;
    logic [1:0]       buf_full_q;
    logic [3:0]       size_q;
    logic [3:0]       byte_cnt_q;
    logic [3:0]       bits_seen_q;
    logic [CNT_W-1:0] rx_count_q;
    logic             rx_bit_q;
    logic             bit_valid_q;
    logic             rx_err_q;
    logic [1:0]       err_code_q;

    // Simultaneous SCL edges can only mean a glitch or a protocol fault, so they kill the transfer like abort.
    logic kill, size_bad, tgt_full, accept, take_bit, byte_end, ack_end, last_byte, done_ok;

    // Decode of the events that drive both the FSM and the datapath.
    always_comb begin
        kill      = abort | (scl_rise & scl_fall);
        size_bad  = (size == 4'd0) || (size > MAX_SZ);
        // A release arriving with the start frees the target first.
        tgt_full  = buf_full_q[wr_sel_q] & ~buf_release[wr_sel_q];
        accept    = (state_q == ST_IDLE) && start_rx && !size_bad && !tgt_full;
        take_bit  = (state_q == ST_BIT) && scl_rise && !kill && (bits_seen_q != 4'd8);
        byte_end  = (state_q == ST_BIT) && scl_fall && !kill && (bits_seen_q == 4'd8);
        ack_end   = (state_q == ST_ACK) && scl_fall && !kill;
        last_byte = ((byte_cnt_q + 4'd1) == size_q);
        done_ok   = (state_q == ST_DONE) && !kill;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: kill wins over everything outside IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_BIT;
            ST_BIT: begin
                if (kill)          state_d = ST_IDLE;
                else if (byte_end) state_d = ST_ACK;
            end
            ST_ACK: begin
                if (kill)         state_d = ST_IDLE;
                else if (ack_end) state_d = last_byte ? ST_DONE : ST_BIT;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: the final byte gets a NACK when configured as master-receiver.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        rx_en     = busy;
        latch0    = busy & ~wr_sel_q;
        latch1    = busy & wr_sel_q;
        ack_drive = (state_q == ST_ACK) && !kill && !(NACK_LAST && last_byte);
        rx_done   = done_ok;
    end

    // Counters, bit sampling, error pulses and buffer ownership.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel_q    <= 1'b0;
            buf_full_q  <= 2'b00;
            size_q      <= 4'd0;
            byte_cnt_q  <= 4'd0;
            bits_seen_q <= 4'd0;
            rx_count_q  <= '0;
            rx_bit_q    <= 1'b0;
            bit_valid_q <= 1'b0;
            rx_err_q    <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            bit_valid_q <= take_bit;
            rx_err_q    <= 1'b0;
            if (take_bit) begin
                rx_bit_q    <= sda_in;
                bits_seen_q <= bits_seen_q + 4'd1;
            end
            if (byte_end)    bits_seen_q <= 4'd0;
            if (ack_end)     byte_cnt_q  <= byte_cnt_q + 4'd1;
            // rx_count shows the index during bit_valid and steps right after it.
            if (bit_valid_q) rx_count_q  <= rx_count_q + CNT_W'(1);
            if (accept) begin
                size_q      <= size;
                byte_cnt_q  <= 4'd0;
                bits_seen_q <= 4'd0;
                rx_count_q  <= '0;
            end
            if (state_q == ST_IDLE && start_rx && size_bad) begin
                rx_err_q   <= 1'b1;
                err_code_q <= ERR_SIZE;
            end else if (state_q == ST_IDLE && start_rx && tgt_full) begin
                rx_err_q   <= 1'b1;
                err_code_q <= ERR_FULL;
            end else if (state_q != ST_IDLE && kill) begin
                rx_err_q   <= 1'b1;
                err_code_q <= ERR_ABORT;
            end
            // Consumer releases and a completing transfer may touch different buffers in one cycle.
            buf_full_q <= (buf_full_q & ~buf_release) |
                          (done_ok ? {wr_sel_q, ~wr_sel_q} : 2'b00);
            if (done_ok) wr_sel_q <= ~wr_sel_q;
        end
    end

    assign rx_bit    = rx_bit_q;
    assign bit_valid = bit_valid_q;
    assign rx_count  = rx_count_q;
    assign buf_full  = buf_full_q;
    assign rx_err    = rx_err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_i2c_rx_ctrl.sv
// Directed bench for i2c_rx_ctrl.
// Inputs change 1 time unit after the rising edge, outputs are sampled there too.
// Each check compares against a hand-derived constant or table entry.
module tb_i2c_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_rx;
    logic [3:0] size;
    logic       scl_rise, scl_fall, sda_in, abort;
    logic [1:0] buf_release;
    logic       rx_en, latch0, latch1, rx_bit, bit_valid, ack_drive, busy, rx_done, rx_err;
    logic [6:0] rx_count;
    logic [1:0] buf_full, err_code;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       sda;
        logic [6:0] exp_count;
    } bit_vec_t;

    typedef struct {
        logic [3:0] size;
        logic [1:0] exp_code;
    } err_vec_t;

    bit_vec_t vec [16];
    err_vec_t evec [4];

    always #5 clk = ~clk;

    i2c_rx_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start_rx(start_rx), .size(size),
        .scl_rise(scl_rise), .scl_fall(scl_fall), .sda_in(sda_in), .abort(abort),
        .buf_release(buf_release), .rx_en(rx_en), .latch0(latch0), .latch1(latch1),
        .rx_bit(rx_bit), .rx_count(rx_count), .bit_valid(bit_valid),
        .ack_drive(ack_drive), .buf_full(buf_full), .busy(busy), .rx_done(rx_done),
        .rx_err(rx_err), .err_code(err_code)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic [3:0] sz, input logic [1:0] rel);
        start_rx = 1'b1; size = sz; buf_release = rel;
        tick();
        start_rx = 1'b0; buf_release = 2'b00;
    endtask

    task automatic send_bit(input logic b, input int idx);
        sda_in = b; scl_rise = 1'b1;
        tick();
        scl_rise = 1'b0;
        chk("bit_valid", 32'(bit_valid), 32'd1);
        chk("rx_bit", 32'(rx_bit), 32'(b));
        chk("rx_count", 32'(rx_count), 32'(idx));
        tick();
    endtask

    task automatic fall();
        scl_fall = 1'b1;
        tick();
        scl_fall = 1'b0;
    endtask

    // ACK slot: entry fall, an ignored rise, and the closing fall.
    task automatic ack_phase(input logic exp_ack, input logic last, input int exp_cnt);
        fall();
        chk("ack_drive_slot", 32'(ack_drive), 32'(exp_ack));
        chk("busy_in_ack", 32'(busy), 32'd1);
        sda_in = 1'b1; scl_rise = 1'b1;
        tick();
        scl_rise = 1'b0;
        chk("rise_ignored_in_ack", 32'(bit_valid), 32'd0);
        fall();
        chk("ack_released", 32'(ack_drive), 32'd0);
        if (last) begin
            chk("rx_done", 32'(rx_done), 32'd1);
            chk("final_rx_count", 32'(rx_count), 32'(exp_cnt));
        end else begin
            chk("next_byte_busy", 32'(busy), 32'd1);
        end
    endtask

    task automatic do_byte(input logic [7:0] data, input int base, input logic exp_ack, input logic last);
        for (int i = 0; i < 8; i++) send_bit(data[7-i], base + i);
        ack_phase(exp_ack, last, base + 8);
    endtask

    initial begin
        logic [15:0] pat;
        pat = 16'hA55A;
        for (int i = 0; i < 16; i++) begin
            vec[i].sda       = pat[15-i];
            vec[i].exp_count = 7'(i);
        end
        evec[0] = '{size: 4'd0,  exp_code: 2'd1};
        evec[1] = '{size: 4'd5,  exp_code: 2'd1};
        evec[2] = '{size: 4'd9,  exp_code: 2'd1};
        evec[3] = '{size: 4'd15, exp_code: 2'd1};

        rst_n = 1'b0; start_rx = 1'b0; size = 4'd0; scl_rise = 1'b0; scl_fall = 1'b0;
        sda_in = 1'b0; abort = 1'b0; buf_release = 2'b00;
        tick(); tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rx_en", 32'(rx_en), 32'd0);
        chk("reset_latch", 32'({latch1, latch0}), 32'd0);
        chk("reset_ack", 32'(ack_drive), 32'd0);
        chk("reset_buf_full", 32'(buf_full), 32'd0);
        chk("reset_rx_count", 32'(rx_count), 32'd0);
        chk("reset_err", 32'(rx_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // size=2 transfer of 0xA55A: ACK on byte 1, NACK on byte 2
        start_req(4'd2, 2'b00);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_rx_en", 32'(rx_en), 32'd1);
        chk("t1_latch", 32'({latch1, latch0}), 32'b01);
        chk("t1_count0", 32'(rx_count), 32'd0);
        for (int i = 0; i < 16; i++) begin
            send_bit(vec[i].sda, int'(vec[i].exp_count));
            if (i == 7)  ack_phase(1'b1, 1'b0, 8);
            if (i == 15) ack_phase(1'b0, 1'b1, 16);
        end
        tick();
        chk("t1_idle", 32'(busy), 32'd0);
        chk("t1_latch_drop", 32'({latch1, latch0}), 32'b00);
        chk("t1_buf_full", 32'(buf_full), 32'b01);

        // reset asserted while ACK is being driven
        start_req(4'd2, 2'b00);
        chk("t2_latch1", 32'({latch1, latch0}), 32'b10);
        for (int i = 0; i < 8; i++) send_bit(1'b1, i);
        fall();
        chk("t2_ack_before_rst", 32'(ack_drive), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t2_rst_ack", 32'(ack_drive), 32'd0);
        chk("t2_rst_busy", 32'(busy), 32'd0);
        chk("t2_rst_latch", 32'({latch1, latch0}), 32'b00);
        chk("t2_rst_buf_full", 32'(buf_full), 32'b00);
        chk("t2_rst_count", 32'(rx_count), 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // two size=1 transfers fill both buffers, third is refused
        start_req(4'd1, 2'b00);
        chk("t3_first_latch", 32'({latch1, latch0}), 32'b01);
        do_byte(8'h3C, 0, 1'b0, 1'b1);
        tick();
        chk("t3_full_01", 32'(buf_full), 32'b01);
        start_req(4'd1, 2'b00);
        chk("t3_second_latch", 32'({latch1, latch0}), 32'b10);
        do_byte(8'hC3, 0, 1'b0, 1'b1);
        tick();
        chk("t3_full_11", 32'(buf_full), 32'b11);
        start_req(4'd1, 2'b00);
        chk("t3_full_err", 32'(rx_err), 32'd1);
        chk("t3_full_code", 32'(err_code), 32'd2);
        chk("t3_full_busy", 32'(busy), 32'd0);
        tick();
        chk("t3_err_pulse", 32'(rx_err), 32'd0);
        buf_release = 2'b01;
        tick();
        buf_release = 2'b00;
        chk("t3_release", 32'(buf_full), 32'b10);

        // size=4 transfer aborted after 11 bits
        start_req(4'd4, 2'b00);
        chk("t4_latch0", 32'({latch1, latch0}), 32'b01);
        do_byte(8'hA5, 0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 8 + i);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_abort_err", 32'(rx_err), 32'd1);
        chk("t4_abort_code", 32'(err_code), 32'd3);
        chk("t4_abort_busy", 32'(busy), 32'd0);
        chk("t4_abort_full", 32'(buf_full), 32'b10);
        start_req(4'd1, 2'b00);
        chk("t4_same_latch", 32'({latch1, latch0}), 32'b01);

        // simultaneous SCL edges while busy
        send_bit(1'b1, 0);
        send_bit(1'b0, 1);
        scl_rise = 1'b1; scl_fall = 1'b1;
        tick();
        scl_rise = 1'b0; scl_fall = 1'b0;
        chk("t5_glitch_err", 32'(rx_err), 32'd1);
        chk("t5_glitch_code", 32'(err_code), 32'd3);
        chk("t5_glitch_idle", 32'(busy), 32'd0);
        chk("t5_glitch_nobv", 32'(bit_valid), 32'd0);

        // release coinciding with start, and with DONE on the other buffer
        start_req(4'd1, 2'b00);
        do_byte(8'h81, 0, 1'b0, 1'b1);
        tick();
        chk("t6_full_11", 32'(buf_full), 32'b11);
        start_req(4'd1, 2'b10);
        chk("t6_start_rel_ok", 32'(rx_err), 32'd0);
        chk("t6_start_rel_latch", 32'({latch1, latch0}), 32'b10);
        chk("t6_after_rel", 32'(buf_full), 32'b01);
        do_byte(8'h7E, 0, 1'b0, 1'b1);
        buf_release = 2'b01;
        tick();
        buf_release = 2'b00;
        chk("t6_done_and_rel", 32'(buf_full), 32'b10);

        // illegal sizes
        for (int i = 0; i < 4; i++) begin
            start_req(evec[i].size, 2'b00);
            chk("size_err", 32'(rx_err), 32'd1);
            chk("size_code", 32'(err_code), 32'(evec[i].exp_code));
            chk("size_busy", 32'(busy), 32'd0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
